// File: rtl/multi_rate_clock_gen_m_pkg.sv
// Shared definitions for the multi-rate clock generator: FSM encoding,
// default half-period table and the half-period lookup helper.
package clock_gen_pkg;

    localparam logic [1:0] ST_LOW     = 2'd0;
    localparam logic [1:0] ST_HIGH    = 2'd1;
    localparam logic [1:0] ST_STRETCH = 2'd2;

    localparam int          TBL_W            = 256;
    localparam logic [31:0] DEF_HALF_PERIODS = {8'd8, 8'd4, 8'd2, 8'd1};

    // Entry k of a packed table of cnt_w-bit fields; a zero entry reads as 1.
    function automatic logic [31:0] half_len(input logic [TBL_W-1:0] tbl,
                                             input int unsigned      k,
                                             input int unsigned      cnt_w);
        logic [31:0] mask;
        logic [31:0] v;
        mask = (cnt_w >= 32) ? '1 : ((32'd1 << cnt_w) - 32'd1);
        v    = 32'(tbl >> (k * cnt_w)) & mask;
        return (v == '0) ? 32'd1 : v;
    endfunction

endpackage

// File: rtl/multi_rate_clock_gen_m_select_sync.sv
// Synchroniser for the asynchronous rate request, followed by a stability
// filter and range check that produce the accepted request pending_op.
module select_sync_m #(
    parameter int NUM_RATES   = 4,
    parameter int SEL_W       = 2,
    parameter int SYNC_STAGES = 2,
    parameter int RESET_RATE  = 3
) (
    input  logic             ck_ip,
    input  logic             resetb,
    input  logic [SEL_W-1:0] select_ip,
    output logic [SEL_W-1:0] pending_op
);

    localparam logic [SEL_W-1:0] RST_SEL = SEL_W'(RESET_RATE);
    localparam logic [SEL_W:0]   NR      = (SEL_W+1)'(NUM_RATES);

    logic [SEL_W-1:0] r_sync [SYNC_STAGES];
    logic             r_agree;
    logic [SEL_W-1:0] r_pending;
    logic             w_agree;
    logic             w_in_range;

    // Agreement must hold on two consecutive cycles, i.e. three equal samples,
    // so a skewed multi-bit change or a single-cycle glitch is never accepted.
    assign w_agree    = (r_sync[SYNC_STAGES-1] == r_sync[SYNC_STAGES-2]);
    assign w_in_range = ({1'b0, r_sync[SYNC_STAGES-1]} < NR);

    always_ff @(posedge ck_ip or negedge resetb) begin
        if (!resetb) begin
            for (int i = 0; i < SYNC_STAGES; i++) r_sync[i] <= RST_SEL;
            r_agree   <= 1'b1;
            r_pending <= RST_SEL;
        end else begin
            r_sync[0] <= select_ip;
            for (int i = 1; i < SYNC_STAGES; i++) r_sync[i] <= r_sync[i-1];
            r_agree <= w_agree;
            if (r_agree && w_agree && w_in_range) r_pending <= r_sync[SYNC_STAGES-1];
        end
    end

    assign pending_op = r_pending;

endmodule

// File: rtl/multi_rate_clock_gen_m.sv
// Glitch-free N-rate clock divider: rate changes only at the low-to-high
// boundary, low phases can be stretched by hold_ip, edge strobes provided.
module multi_rate_clock_gen_m
    import clock_gen_pkg::*;
#(
    parameter int                           NUM_RATES    = 4,
    parameter int                           SEL_W        = 2,
    parameter int                           CNT_W        = 8,
    parameter logic [NUM_RATES*CNT_W-1:0]   HALF_PERIODS = DEF_HALF_PERIODS,
    parameter int                           SYNC_STAGES  = 2,
    parameter int                           RESET_RATE   = 3
) (
    input  logic             ck_ip,
    input  logic             resetb,
    input  logic [SEL_W-1:0] select_ip,
    input  logic             hold_ip,
    output logic             ck_op,
    output logic             rise_en_op,
    output logic             fall_en_op,
    output logic [SEL_W-1:0] selected_op,
    output logic             switching_op
);

    localparam int               NSEL    = 2**SEL_W;
    localparam logic [TBL_W-1:0] W_TBL   = TBL_W'(HALF_PERIODS);
    localparam logic [CNT_W-1:0] RST_CNT = CNT_W'(half_len(W_TBL, RESET_RATE, CNT_W) - 32'd1);
    localparam logic [SEL_W-1:0] RST_SEL = SEL_W'(RESET_RATE);

    logic [CNT_W-1:0] w_half [NSEL];
    logic [SEL_W-1:0] w_pending;
    logic             w_do_rise;

    logic [1:0]       r_state;
    logic [CNT_W-1:0] r_cnt;
    logic             r_ck;
    logic             r_rise;
    logic             r_fall;
    logic [SEL_W-1:0] r_sel;
    logic             r_sw;

    for (genvar k = 0; k < NSEL; k++) begin : g_half
        if (k < NUM_RATES) begin : g_rate
            assign w_half[k] = CNT_W'(half_len(W_TBL, k, CNT_W));
        end else begin : g_unused
            assign w_half[k] = CNT_W'(1);
        end
    end

    select_sync_m #(
        .NUM_RATES   (NUM_RATES),
        .SEL_W       (SEL_W),
        .SYNC_STAGES (SYNC_STAGES),
        .RESET_RATE  (RESET_RATE)
    ) u_sync (
        .ck_ip      (ck_ip),
        .resetb     (resetb),
        .select_ip  (select_ip),
        .pending_op (w_pending)
    );

    // The rise is the single point where a new rate is adopted.
    assign w_do_rise = !hold_ip && ((r_state == ST_LOW && r_cnt == '0) ||
                                    (r_state == ST_STRETCH));

    always_ff @(posedge ck_ip or negedge resetb) begin
        if (!resetb) begin
            r_state <= ST_LOW;
            r_cnt   <= RST_CNT;
            r_ck    <= 1'b0;
            r_rise  <= 1'b0;
            r_fall  <= 1'b0;
            r_sel   <= RST_SEL;
            r_sw    <= 1'b0;
        end else begin
            r_rise <= 1'b0;
            r_fall <= 1'b0;
            r_sw   <= (w_pending != r_sel);
            if (w_do_rise) begin
                r_sel   <= w_pending;
                r_ck    <= 1'b1;
                r_cnt   <= w_half[w_pending] - 1'b1;
                r_rise  <= 1'b1;
                r_state <= ST_HIGH;
            end else begin
                case (r_state)
                    ST_LOW: begin
                        if (r_cnt != '0) r_cnt <= r_cnt - 1'b1;
                        else             r_state <= ST_STRETCH;
                    end
                    ST_STRETCH: ;
                    ST_HIGH: begin
                        if (r_cnt != '0) begin
                            r_cnt <= r_cnt - 1'b1;
                        end else begin
                            // Low phase reuses the rate of the high phase it follows.
                            r_ck    <= 1'b0;
                            r_cnt   <= w_half[r_sel] - 1'b1;
                            r_fall  <= 1'b1;
                            r_state <= ST_LOW;
                        end
                    end
                    default: begin
                        r_ck    <= 1'b0;
                        r_state <= ST_LOW;
                    end
                endcase
            end
        end
    end

    assign ck_op        = r_ck;
    assign rise_en_op   = r_rise;
    assign fall_en_op   = r_fall;
    assign selected_op  = r_sel;
    assign switching_op = r_sw;

endmodule

// File: tb/tb_multi_rate_clock_gen_m.sv
// Randomised and directed checks of the clock generator against a
// phase-length reference model.
module tb_multi_rate_clock_gen_m;

    logic       ck_ip = 1'b0;
    logic       resetb = 1'b0;
    logic [1:0] select_ip = 2'd3;
    logic       hold_ip = 1'b0;
    logic       ck_op, rise_en_op, fall_en_op, switching_op;
    logic [1:0] selected_op;

    logic [1:0] sel3 = 2'd2;
    logic       ck3, rise3, fall3, sw3;
    logic [1:0] seld3;

    int checks = 0;
    int errors = 0;

    // Reference model: level, cycles spent in current phase, rate of the phase,
    // accepted request and the last three select samples.
    bit         m_ck, m_rise, m_fall, m_sw;
    int         m_el;
    logic [1:0] m_rate, m_pend, h0, h1, h2;

    always #5 ck_ip = ~ck_ip;

    multi_rate_clock_gen_m dut (
        .ck_ip(ck_ip), .resetb(resetb), .select_ip(select_ip), .hold_ip(hold_ip),
        .ck_op(ck_op), .rise_en_op(rise_en_op), .fall_en_op(fall_en_op),
        .selected_op(selected_op), .switching_op(switching_op)
    );

    multi_rate_clock_gen_m #(
        .NUM_RATES(3), .HALF_PERIODS({8'd4, 8'd2, 8'd1}), .RESET_RATE(2)
    ) dut3 (
        .ck_ip(ck_ip), .resetb(resetb), .select_ip(sel3), .hold_ip(1'b0),
        .ck_op(ck3), .rise_en_op(rise3), .fall_en_op(fall3),
        .selected_op(seld3), .switching_op(sw3)
    );

    function automatic int half(input logic [1:0] r);
        case (r)
            2'd0:    return 1;
            2'd1:    return 2;
            2'd2:    return 4;
            default: return 8;
        endcase
    endfunction

    task automatic model_reset();
        m_ck = 0; m_rise = 0; m_fall = 0; m_sw = 0; m_el = 0;
        m_rate = 2'd3; m_pend = 2'd3; h0 = 2'd3; h1 = 2'd3; h2 = 2'd3;
    endtask

    // One master-clock cycle: model the edge, return at the following negedge.
    task automatic tick();
        logic [1:0] pend_old, rate_old;
        @(posedge ck_ip);
        pend_old = m_pend; rate_old = m_rate;
        m_rise = 0; m_fall = 0;
        m_el++;
        if (m_ck) begin
            if (m_el >= half(rate_old)) begin m_ck = 0; m_el = 0; m_fall = 1; end
        end else if (m_el >= half(rate_old) && !hold_ip) begin
            m_rate = pend_old; m_ck = 1; m_el = 0; m_rise = 1;
        end
        m_sw = (pend_old != rate_old);
        if (h0 == h1 && h1 == h2) m_pend = h1;
        h2 = h1; h1 = h0; h0 = select_ip;
        @(negedge ck_ip);
    endtask

    task automatic test_reset();
        resetb = 1'b0; select_ip = 2'd3; hold_ip = 1'b0;
        model_reset();
        repeat (3) @(negedge ck_ip);
        checks++;
        if ({ck_op, rise_en_op, fall_en_op, selected_op, switching_op} !== 6'b000_11_0) begin
            errors++;
            $display("FAIL reset_state got %b want 000110",
                     {ck_op, rise_en_op, fall_en_op, selected_op, switching_op});
        end
        checks++;
        if ({ck3, seld3, sw3} !== 4'b0_10_0) begin
            errors++; $display("FAIL reset_state3 got %b want 0100", {ck3, seld3, sw3});
        end
        resetb = 1'b1;
    endtask

    task automatic test_slow();
        int first_rise = -1;
        for (int i = 1; i <= 40; i++) begin
            tick();
            checks++;
            if ({ck_op, rise_en_op, fall_en_op, selected_op, switching_op} !==
                {m_ck, m_rise, m_fall, m_rate, m_sw}) begin
                errors++;
                $display("FAIL slow_cycle %0d got %b want %b", i,
                         {ck_op, rise_en_op, fall_en_op, selected_op, switching_op},
                         {m_ck, m_rise, m_fall, m_rate, m_sw});
            end
            if (ck_op === 1'b1 && first_rise < 0) first_rise = i;
        end
        checks++;
        if (first_rise != 8) begin
            errors++; $display("FAIL slow_first_low got %0d want 8", first_rise);
        end
    endtask

    task automatic test_switch_3_to_0();
        int n = 0, sw_at = -1;
        do begin tick(); n++; end while (!m_rise && n < 40);
        repeat (2) tick();
        select_ip = 2'd0;
        for (int i = 1; i <= 40; i++) begin
            tick();
            checks++;
            if ({ck_op, rise_en_op, fall_en_op, selected_op, switching_op} !==
                {m_ck, m_rise, m_fall, m_rate, m_sw}) begin
                errors++;
                $display("FAIL switch30_cycle %0d got %b want %b", i,
                         {ck_op, rise_en_op, fall_en_op, selected_op, switching_op},
                         {m_ck, m_rise, m_fall, m_rate, m_sw});
            end
            if (switching_op === 1'b1 && sw_at < 0) sw_at = i;
        end
        checks++;
        if (sw_at != 5) begin errors++; $display("FAIL switch30_latency got %0d want 5", sw_at); end
        checks++;
        if ({selected_op, switching_op} !== 3'b00_0) begin
            errors++; $display("FAIL switch30_final got %b want 000", {selected_op, switching_op});
        end
    endtask

    task automatic test_0_to_2();
        int run = 0, last_run = 0;
        logic prev;
        select_ip = 2'd2;
        prev = ck_op;
        for (int i = 1; i <= 40; i++) begin
            tick();
            checks++;
            if ({ck_op, rise_en_op, fall_en_op, selected_op, switching_op} !==
                {m_ck, m_rise, m_fall, m_rate, m_sw}) begin
                errors++;
                $display("FAIL switch02_cycle %0d got %b want %b", i,
                         {ck_op, rise_en_op, fall_en_op, selected_op, switching_op},
                         {m_ck, m_rise, m_fall, m_rate, m_sw});
            end
            if (ck_op !== prev) begin last_run = run; run = 1; end else run++;
            prev = ck_op;
        end
        checks++;
        if (last_run != half(2'd2)) begin
            errors++; $display("FAIL switch02_phase got %0d want %0d", last_run, half(2'd2));
        end
    endtask

    task automatic test_hold();
        int n = 0, low_len = 1, high_len = 0;
        select_ip = 2'd1;
        do begin tick(); n++; end while (!(m_fall && m_rate == 2'd1) && n < 60);
        repeat (half(2'd1) - 1) begin tick(); if (ck_op === 1'b0) low_len++; end
        hold_ip = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            if (i == 0) select_ip = 2'd2;
            checks++;
            if ({ck_op, rise_en_op, fall_en_op} !== {m_ck, m_rise, m_fall}) begin
                errors++;
                $display("FAIL hold_cycle %0d got %b want %b", i,
                         {ck_op, rise_en_op, fall_en_op}, {m_ck, m_rise, m_fall});
            end
            if (ck_op === 1'b0) low_len++;
        end
        hold_ip = 1'b0;
        n = 0;
        do begin tick(); n++; if (ck_op === 1'b0) low_len++; end while (ck_op !== 1'b1 && n < 20);
        checks++;
        if (low_len != half(2'd1) + 5) begin
            errors++; $display("FAIL hold_low_len got %0d want %0d", low_len, half(2'd1) + 5);
        end
        n = 0;
        while (ck_op === 1'b1 && n < 20) begin high_len++; tick(); n++; end
        checks++;
        if (high_len != half(2'd2) || selected_op !== 2'd2) begin
            errors++;
            $display("FAIL hold_new_rate got len %0d sel %0d want len %0d sel 2",
                     high_len, selected_op, half(2'd2));
        end
    endtask

    task automatic test_glitch();
        bit any_sw = 0;
        repeat (10) tick();
        select_ip = 2'd0;
        tick();
        select_ip = 2'd2;
        for (int i = 1; i <= 24; i++) begin
            tick();
            checks++;
            if ({ck_op, rise_en_op, fall_en_op, selected_op, switching_op} !==
                {m_ck, m_rise, m_fall, m_rate, m_sw}) begin
                errors++;
                $display("FAIL glitch_cycle %0d got %b want %b", i,
                         {ck_op, rise_en_op, fall_en_op, selected_op, switching_op},
                         {m_ck, m_rise, m_fall, m_rate, m_sw});
            end
            if (switching_op === 1'b1) any_sw = 1;
        end
        checks++;
        if (any_sw || selected_op !== 2'd2) begin
            errors++; $display("FAIL glitch_ignored got sw %0d sel %0d want sw 0 sel 2",
                               any_sw, selected_op);
        end
    endtask

    task automatic test_range();
        int n = 0;
        sel3 = 2'd3;
        for (int i = 1; i <= 20; i++) begin
            tick();
            checks++;
            if ({seld3, sw3} !== 3'b10_0) begin
                errors++; $display("FAIL range_ignored cycle %0d got %b want 100", i, {seld3, sw3});
            end
        end
        sel3 = 2'd0;
        do begin tick(); n++; end while (sw3 !== 1'b1 && n < 12);
        checks++;
        if (sw3 !== 1'b1) begin errors++; $display("FAIL range_valid_accept got %b want 1", sw3); end
    endtask

    task automatic test_reset_mid();
        int n = 0, first_rise = -1;
        select_ip = 2'd0;
        do begin tick(); n++; end while (!(m_ck && m_rate == 2'd0) && n < 60);
        #2 resetb = 1'b0;
        #1;
        checks++;
        if ({ck_op, rise_en_op, fall_en_op, selected_op} !== 5'b000_11) begin
            errors++; $display("FAIL reset_mid got %b want 00011",
                               {ck_op, rise_en_op, fall_en_op, selected_op});
        end
        @(negedge ck_ip);
        select_ip = 2'd3;
        model_reset();
        resetb = 1'b1;
        for (int i = 1; i <= 30; i++) begin
            tick();
            checks++;
            if ({ck_op, rise_en_op, fall_en_op, selected_op, switching_op} !==
                {m_ck, m_rise, m_fall, m_rate, m_sw}) begin
                errors++;
                $display("FAIL reset_resume_cycle %0d got %b want %b", i,
                         {ck_op, rise_en_op, fall_en_op, selected_op, switching_op},
                         {m_ck, m_rise, m_fall, m_rate, m_sw});
            end
            if (ck_op === 1'b1 && first_rise < 0) first_rise = i;
        end
        checks++;
        if (first_rise != 8) begin
            errors++; $display("FAIL reset_resume_low got %0d want 8", first_rise);
        end
    endtask

    task automatic test_random();
        int left = 0;
        for (int i = 1; i <= 600; i++) begin
            if (left == 0) begin
                select_ip = 2'($urandom_range(0, 3));
                left = $urandom_range(1, 25);
            end
            left--;
            hold_ip = ($urandom_range(0, 7) == 0);
            tick();
            checks++;
            if ({ck_op, rise_en_op, fall_en_op, selected_op, switching_op} !==
                {m_ck, m_rise, m_fall, m_rate, m_sw}) begin
                errors++;
                $display("FAIL random_cycle %0d got %b want %b", i,
                         {ck_op, rise_en_op, fall_en_op, selected_op, switching_op},
                         {m_ck, m_rise, m_fall, m_rate, m_sw});
            end
        end
        hold_ip = 1'b0;
    endtask

    initial begin
        test_reset();
        test_slow();
        test_switch_3_to_0();
        test_0_to_2();
        test_hold();
        test_glitch();
        test_range();
        test_reset_mid();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
